// File: rtl/intr_encoder83_pkg.sv
// Shared definitions for the 8-to-3 interrupt encoder: enable code and FSM states.
package intr_encoder83_pkg;

  localparam logic [2:0] EN_ACTIVE = 3'b100;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/intr_encoder83_prio_enc8.sv
// Combinational 8-input priority encoder; HIGH_FIRST selects whether bit 7 or bit 0 wins.
module prio_enc8 #(
  parameter int unsigned HIGH_FIRST = 1
) (
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    idx = '0;
    any = |in;
    // Scan toward the winning end so the last hit found is the highest-priority one.
    for (int unsigned i = 0; i < 8; i++) begin
      if (HIGH_FIRST != 0) begin
        if (in[i]) idx = 3'(i);
      end else begin
        if (in[7 - i]) idx = 3'(7 - i);
      end
    end
  end

endmodule

// File: rtl/intr_encoder83.sv
// Registered 8-to-3 priority encoder with pending latch, sticky overflow and valid/ready output.
module intr_encoder83
  import intr_encoder83_pkg::*;
#(
  parameter int unsigned EDGE_MODE  = 1,
  parameter int unsigned HIGH_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic [2:0] en,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic       out_valid,
  output logic [2:0] code,
  output logic       gs,
  output logic [7:0] pending,
  output logic       ovf
);

  state_e     state_q, state_d;
  logic [7:0] req_q;
  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q, code_d;
  logic       gs_q, ovf_q, ovf_d;
  logic [7:0] set, clr, eligible;
  logic [2:0] idx;
  logic       any;

  always_comb begin
    set = (EDGE_MODE != 0) ? (req & ~req_q) : req;
    clr = '0;
    if (state_q == ST_PRESENT && out_ready) clr = 8'b1 << code_q;
    // Set takes priority over clear on the same bit.
    pending_d = (pending_q & ~clr) | set;
    ovf_d     = (|(set & pending_q & ~clr)) | (ovf_q & ~clr_ovf);
    eligible  = pending_q & ~mask;
  end

  prio_enc8 #(.HIGH_FIRST(HIGH_FIRST)) u_prio (
    .in  (eligible),
    .idx (idx),
    .any (any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (en == EN_ACTIVE && any) begin
          code_d  = idx;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      pending_q <= '0;
      code_q    <= '0;
      gs_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      pending_q <= pending_d;
      code_q    <= code_d;
      gs_q      <= |eligible;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign code      = code_q;
  assign gs        = gs_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule
